// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit CRC sequencer.
// No logic of its own; the state enum and CRC16 constants live here.
// The receive-side checker reuses CRC16_RESIDUAL.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DATA,
    ST_CRC,
    ST_DONE
  } state_e;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // One serial CRC16 step: shift left, fold in the polynomial when msb ^ data is set.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        din,
                                             input logic [15:0] poly);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_tx_crc_seq_if.sv
// Byte-in / bit-out bundle between the packet assembler, the sequencer and the stuffer.
// Pure wiring, no latency.
// tx_valid/tx_ready handshake upstream; downstream has no backpressure (bit-time strobe paced).
interface usb_tx_crc_seq_if;
  logic       clk_trans;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_zlp;
  logic       crc_en;
  logic       abort;
  logic       tx_bit;
  logic       tx_bit_valid;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  // Assembler / bench side.
  modport master (
    output clk_trans, tx_data, tx_valid, tx_last, tx_zlp, crc_en, abort,
    input  tx_ready, tx_bit, tx_bit_valid, tx_busy, tx_done, tx_err
  );

  // Sequencer side.
  modport slave (
    input  clk_trans, tx_data, tx_valid, tx_last, tx_zlp, crc_en, abort,
    output tx_ready, tx_bit, tx_bit_valid, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/usb_crc16_gen.sv
// Serial CRC16 LFSR with synchronous init, data-feed and dump (plain shift-out) modes.
// Register updates one cycle after shift_en/init; crc_msb is the current register msb.
// No backpressure: the owner decides when to shift.
module usb_crc16_gen
  import usb_pkg::*;
#(
  parameter logic [15:0] INIT = CRC16_INIT,
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic shift_en,
  input  logic dump,
  input  logic data_in,
  output logic crc_msb
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Next LFSR value: init wins, then either feed a data bit or shift the result out.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = INIT;
    end else if (shift_en) begin
      crc_d = dump ? {crc_q[14:0], 1'b0} : crc16_step(crc_q, data_in, POLY);
    end
  end

  // LFSR register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= INIT;
    else        crc_q <= crc_d;
  end

  assign crc_msb = crc_q[15];

endmodule

// File: rtl/usb_tx_crc_seq.sv
// Serializes payload bytes LSB-first on clk_trans and appends the inverted CRC16 MSB-first.
// First bit on the first strobe >=2 cycles after acceptance; bytes reload with no gap.
// One-byte hold register: tx_ready drops while it is full, after the last byte, and outside IDLE/DATA.
module usb_tx_crc_seq
  import usb_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = CRC16_INIT,
  parameter logic [15:0] CRC_POLY = CRC16_POLY
) (
  input logic              clk,
  input logic              rst_n,
  usb_tx_crc_seq_if.slave  bus
);

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        hold_last_q, hold_last_d;
  logic [7:0]  shift_q, shift_d;
  logic        shift_last_q, shift_last_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  crc_cnt_q, crc_cnt_d;
  logic        crc_en_q, crc_en_d;
  logic        last_seen_q, last_seen_d;
  logic        tx_bit_q, tx_bit_d;
  logic        tx_bit_valid_q, tx_bit_valid_d;
  logic        tx_err_q, tx_err_d;

  logic        accept;
  logic        crc_init;
  logic        crc_shift;
  logic        crc_dump;
  logic        crc_msb;

  assign bus.tx_ready = !hold_vld_q && !last_seen_q &&
                        (state_q == ST_IDLE || state_q == ST_DATA);
  assign accept       = bus.tx_valid && bus.tx_ready;

  usb_crc16_gen #(
    .INIT (CRC_INIT),
    .POLY (CRC_POLY)
  ) u_crc (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (crc_init),
    .shift_en (crc_shift),
    .dump     (crc_dump),
    .data_in  (shift_q[0]),
    .crc_msb  (crc_msb)
  );

  // Next-state and datapath control; abort overrides every other action.
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    hold_vld_d     = hold_vld_q;
    hold_last_d    = hold_last_q;
    shift_d        = shift_q;
    shift_last_d   = shift_last_q;
    cnt_d          = cnt_q;
    crc_cnt_d      = crc_cnt_q;
    crc_en_d       = crc_en_q;
    last_seen_d    = last_seen_q;
    tx_bit_d       = tx_bit_q;
    tx_bit_valid_d = 1'b0;
    tx_err_d       = 1'b0;
    crc_init       = 1'b0;
    crc_shift      = 1'b0;
    crc_dump       = 1'b0;

    if (bus.abort) begin
      state_d     = ST_IDLE;
      hold_vld_d  = 1'b0;
      last_seen_d = 1'b0;
      cnt_d       = 3'd0;
    end else begin
      if (accept) begin
        hold_d      = bus.tx_data;
        hold_vld_d  = 1'b1;
        hold_last_d = bus.tx_last;
        if (bus.tx_last) last_seen_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            crc_en_d = bus.crc_en;
            crc_init = 1'b1;
            state_d  = ST_LOAD;
          end else if (bus.tx_zlp && !bus.tx_valid) begin
            crc_init  = 1'b1;
            crc_cnt_d = 4'd0;
            state_d   = ST_CRC;
          end
        end

        ST_LOAD: begin
          shift_d      = hold_q;
          shift_last_d = hold_last_q;
          hold_vld_d   = 1'b0;
          cnt_d        = 3'd0;
          state_d      = ST_DATA;
        end

        ST_DATA: begin
          if (bus.clk_trans) begin
            tx_bit_d       = shift_q[0];
            tx_bit_valid_d = 1'b1;
            shift_d        = {1'b0, shift_q[7:1]};
            cnt_d          = cnt_q + 3'd1;
            crc_shift      = 1'b1;
            if (cnt_q == 3'd7) begin
              if (hold_vld_q) begin
                shift_d      = hold_q;
                shift_last_d = hold_last_q;
                hold_vld_d   = 1'b0;
                cnt_d        = 3'd0;
              end else if (shift_last_q) begin
                crc_cnt_d = 4'd0;
                state_d   = crc_en_q ? ST_CRC : ST_DONE;
              end else begin
                // Underrun: a byte handed over on this very cycle is dropped
                // so IDLE never starts with a stale hold register.
                tx_err_d   = 1'b1;
                hold_vld_d = 1'b0;
                state_d    = ST_IDLE;
              end
            end
          end
        end

        ST_CRC: begin
          if (bus.clk_trans) begin
            tx_bit_d       = ~crc_msb;
            tx_bit_valid_d = 1'b1;
            crc_shift      = 1'b1;
            crc_dump       = 1'b1;
            crc_cnt_d      = crc_cnt_q + 4'd1;
            if (crc_cnt_q == 4'd15) state_d = ST_DONE;
          end
        end

        ST_DONE: state_d = ST_IDLE;

        default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_IDLE) last_seen_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      hold_q         <= 8'h00;
      hold_vld_q     <= 1'b0;
      hold_last_q    <= 1'b0;
      shift_q        <= 8'h00;
      shift_last_q   <= 1'b0;
      cnt_q          <= 3'd0;
      crc_cnt_q      <= 4'd0;
      crc_en_q       <= 1'b0;
      last_seen_q    <= 1'b0;
      tx_bit_q       <= 1'b0;
      tx_bit_valid_q <= 1'b0;
      tx_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      hold_vld_q     <= hold_vld_d;
      hold_last_q    <= hold_last_d;
      shift_q        <= shift_d;
      shift_last_q   <= shift_last_d;
      cnt_q          <= cnt_d;
      crc_cnt_q      <= crc_cnt_d;
      crc_en_q       <= crc_en_d;
      last_seen_q    <= last_seen_d;
      tx_bit_q       <= tx_bit_d;
      tx_bit_valid_q <= tx_bit_valid_d;
      tx_err_q       <= tx_err_d;
    end
  end

  assign bus.tx_bit       = tx_bit_q;
  assign bus.tx_bit_valid = tx_bit_valid_q;
  assign bus.tx_busy      = (state_q != ST_IDLE);
  assign bus.tx_done      = (state_q == ST_DONE) && !bus.abort;
  assign bus.tx_err       = tx_err_q;

endmodule

// File: tb/tb_usb_tx_crc_seq.sv
// Randomized and directed bench for usb_tx_crc_seq against a bit-list reference model.
// Inputs change on the falling clock edge; outputs are sampled just after it.
// The bit-time strobe is free-running with a per-packet period unless a test drives it by hand.
module tb_usb_tx_crc_seq;

  localparam int unsigned M_INIT = 32'h0000_FFFF;
  localparam int unsigned M_POLY = 32'h0000_8005;

  logic clk;
  logic rst_n;

  usb_tx_crc_seq_if bus ();

  usb_tx_crc_seq #(
    .CRC_INIT (16'hFFFF),
    .CRC_POLY (16'h8005)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  bit         got_bits[$];
  int         vtimes[$];
  bit         exp_bits[$];
  logic [7:0] pkt[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         done_cyc = 0;
  int         err_cyc = 0;
  int         period = 4;
  bit         gen_en = 1'b1;
  int         sctr = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: payload bits LSB-first, then the complement of the CRC remainder MSB-first.
  function automatic void model_packet(input bit ce);
    int unsigned r;
    r = M_INIT;
    exp_bits.delete();
    foreach (pkt[k]) begin
      for (int i = 0; i < 8; i++) begin
        int unsigned b;
        b = (int'(pkt[k]) >> i) & 1;
        exp_bits.push_back(b[0]);
        if (((r >> 15) & 1) != b) r = ((r << 1) ^ M_POLY) & 32'hFFFF;
        else                      r = (r << 1) & 32'hFFFF;
      end
    end
    if (ce) begin
      for (int i = 15; i >= 0; i--) exp_bits.push_back(((r >> i) & 1) == 0);
    end
  endfunction

  // Bit-time strobe generator.
  initial begin
    forever begin
      @(negedge clk);
      if (gen_en) begin
        sctr = (sctr + 1) % period;
        bus.clk_trans = (sctr == 0);
      end
    end
  end

  // Output monitor.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (bus.tx_bit_valid === 1'b1) begin
        got_bits.push_back(bus.tx_bit);
        vtimes.push_back(cyc);
      end
      if (bus.tx_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (bus.tx_err === 1'b1)  begin err_cnt++;  err_cyc  = cyc; end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, int'(bus.tx_ready), 1);
    check_eq({tag, "_bit"}, int'(bus.tx_bit), 0);
    check_eq({tag, "_bit_valid"}, int'(bus.tx_bit_valid), 0);
    check_eq({tag, "_busy"}, int'(bus.tx_busy), 0);
    check_eq({tag, "_done"}, int'(bus.tx_done), 0);
    check_eq({tag, "_err"}, int'(bus.tx_err), 0);
  endtask

  task automatic push_byte(input logic [7:0] d, input bit last, input bit ce, input int dly);
    int budget;
    budget = 500;
    bus.tx_valid = 1'b0;
    repeat (dly) @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = last;
    bus.crc_en   = ce;
    while (!bus.tx_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("ready_wait", int'(budget > 0), 1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check_eq("ready_drop", int'(bus.tx_ready), 0);
  endtask

  task automatic wait_end(input int d0, input int e0);
    int budget;
    budget = 3000;
    while (done_cnt == d0 && err_cnt == e0 && budget > 0) begin
      @(negedge clk);
      #2;
      budget--;
    end
    check_eq("end_timeout", int'(budget > 0), 1);
    @(negedge clk);
    #2;
    check_eq("busy_after", int'(bus.tx_busy), 0);
    check_eq("ready_after", int'(bus.tx_ready), 1);
  endtask

  task automatic check_packet(input int d0, input int e0, input bit exp_err);
    int gaps;
    int n;
    gaps = 0;
    check_eq("n_bits", got_bits.size(), exp_bits.size());
    n = (got_bits.size() < exp_bits.size()) ? got_bits.size() : exp_bits.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("bit%0d", i), int'(got_bits[i]), int'(exp_bits[i]));
    for (int i = 1; i < vtimes.size(); i++) if (vtimes[i] - vtimes[i-1] != period) gaps++;
    check_eq("strobe_gaps", gaps, 0);
    check_eq("done_pulses", done_cnt - d0, exp_err ? 0 : 1);
    check_eq("err_pulses", err_cnt - e0, exp_err ? 1 : 0);
    if (vtimes.size() > 0)
      check_eq("end_align", exp_err ? err_cyc : done_cyc, vtimes[vtimes.size()-1]);
  endtask

  // Sends pkt (or a ZLP) with the free-running strobe and checks the whole packet.
  task automatic run_packet(input bit ce, input bit zlp);
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    if (zlp) pkt.delete();
    model_packet(zlp ? 1'b1 : ce);
    got_bits.delete();
    vtimes.delete();
    if (zlp) begin
      @(negedge clk);
      bus.tx_zlp = 1'b1;
      @(negedge clk);
      bus.tx_zlp = 1'b0;
    end else begin
      foreach (pkt[k]) push_byte(pkt[k], k == pkt.size() - 1, ce, $urandom_range(0, 3));
    end
    wait_end(d0, e0);
    check_packet(d0, e0, 1'b0);
  endtask

  initial begin
    int d0;
    int e0;
    int budget;

    bus.clk_trans = 1'b0;
    bus.tx_data   = 8'h00;
    bus.tx_valid  = 1'b0;
    bus.tx_last   = 1'b0;
    bus.tx_zlp    = 1'b0;
    bus.crc_en    = 1'b0;
    bus.abort     = 1'b0;
    rst_n         = 1'b0;

    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-length packet: CRC of nothing.
    period = 4;
    run_packet(1'b1, 1'b1);

    // Single byte with CRC.
    period = 2;
    pkt = {};
    pkt.push_back(8'h01);
    run_packet(1'b1, 1'b0);

    // Four back-to-back bytes on a strobe every cycle.
    period = 1;
    pkt = {};
    for (int i = 0; i < 4; i++) pkt.push_back(8'(i));
    begin
      d0 = done_cnt;
      e0 = err_cnt;
      model_packet(1'b1);
      got_bits.delete();
      vtimes.delete();
      foreach (pkt[k]) push_byte(pkt[k], k == 3, 1'b1, 0);
      wait_end(d0, e0);
      check_packet(d0, e0, 1'b0);
    end

    // Underrun after one non-last byte.
    period = 3;
    pkt = {};
    pkt.push_back(8'hA5);
    d0 = done_cnt;
    e0 = err_cnt;
    model_packet(1'b0);
    got_bits.delete();
    vtimes.delete();
    push_byte(8'hA5, 1'b0, 1'b1, 0);
    wait_end(d0, e0);
    check_packet(d0, e0, 1'b1);

    // No CRC appended.
    period = 3;
    pkt = {};
    pkt.push_back(8'hFF);
    pkt.push_back(8'h00);
    run_packet(1'b0, 1'b0);

    // Abort on the 5th data strobe, strobe driven by hand.
    @(negedge clk);
    gen_en = 1'b0;
    bus.clk_trans = 1'b0;
    pkt = {};
    pkt.push_back(8'h2C);
    pkt.push_back(8'h5A);
    model_packet(1'b1);
    d0 = done_cnt;
    e0 = err_cnt;
    got_bits.delete();
    vtimes.delete();
    push_byte(8'h2C, 1'b0, 1'b1, 0);
    push_byte(8'h5A, 1'b1, 1'b1, 0);
    repeat (4) begin
      @(negedge clk);
      bus.clk_trans = 1'b1;
      @(negedge clk);
      bus.clk_trans = 1'b0;
    end
    @(negedge clk);
    bus.clk_trans = 1'b1;
    bus.abort     = 1'b1;
    @(negedge clk);
    bus.clk_trans = 1'b0;
    bus.abort     = 1'b0;
    #2;
    check_eq("abort_bit_valid", int'(bus.tx_bit_valid), 0);
    check_eq("abort_busy", int'(bus.tx_busy), 0);
    check_eq("abort_ready", int'(bus.tx_ready), 1);
    check_eq("abort_nbits", got_bits.size(), 4);
    check_eq("abort_bit_hold", int'(bus.tx_bit), int'(exp_bits[3]));
    check_eq("abort_no_done", done_cnt - d0, 0);
    check_eq("abort_no_err", err_cnt - e0, 0);
    gen_en = 1'b1;
    period = 4;
    run_packet(1'b1, 1'b1);

    // Asynchronous reset in the middle of the CRC field.
    period = 2;
    pkt = {};
    pkt.push_back(8'h01);
    got_bits.delete();
    vtimes.delete();
    push_byte(8'h01, 1'b1, 1'b1, 0);
    budget = 2000;
    while (got_bits.size() < 12 && budget > 0) begin
      @(negedge clk);
      #2;
      budget--;
    end
    check_eq("crc_reach", int'(budget > 0), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized packets.
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      period = $urandom_range(1, 4);
      if ($urandom_range(0, 4) == 0) begin
        run_packet(1'b1, 1'b1);
      end else begin
        int len;
        len = $urandom_range(1, 6);
        pkt = {};
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
        run_packet(1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_tx_crc_seq.md
Name: usb_tx_crc_seq

Overview:
Transmit-side packet sequencer for the USB data path. It accepts payload bytes over a valid/ready handshake, serializes them LSB-first on the bit-time strobe `clk_trans`, and runs a CRC16 over every payload bit. After the last byte it appends the 16 inverted CRC bits. Sits between the packet assembler (upstream) and the bit-stuffer/NRZI encoder (downstream).

Parameters:
- CRC_INIT, 16'hFFFF, CRC register value loaded at packet start.
- CRC_POLY, 16'h8005, CRC16 generator polynomial (x^16+x^15+x^2+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clk_trans  in  1  one-cycle bit-time strobe; all bit activity advances only on cycles where it is high.
- tx_data  in  8  payload byte.
- tx_valid  in  1  tx_data valid.
- tx_last  in  1  qualifies tx_data as the final payload byte.
- tx_ready  out  1  byte accepted on a cycle where tx_valid && tx_ready.
- tx_zlp  in  1  IDLE-only pulse: start a zero-length packet (CRC only).
- crc_en  in  1  sampled with the first byte; 0 means no CRC is appended.
- abort  in  1  synchronous flush.
- tx_bit  out  1  serial output bit.
- tx_bit_valid  out  1  one-cycle pulse; tx_bit was updated on this edge.
- tx_busy  out  1  state != IDLE.
- tx_done  out  1  one-cycle pulse at packet end.
- tx_err  out  1  one-cycle pulse on underrun.

Behaviour:
- Reset values: all outputs 0 except tx_ready=1; state=IDLE, hold/shift registers empty, crc=CRC_INIT.
- Storage: one-byte hold register (hold_vld, hold_last) plus an 8-bit shift register with a 3-bit bit counter.
- tx_ready = !hold_vld && !last_seen && state in {IDLE, DATA}. last_seen is set when a byte with tx_last is accepted and cleared on return to IDLE.
- IDLE:
  - Accepted byte goes to hold. crc_en is latched and crc is loaded with CRC_INIT. Next state: LOAD.
  - tx_zlp (with no tx_valid) loads crc with CRC_INIT and goes to CRC. tx_valid has priority over tx_zlp.
- LOAD: move hold to shift, clear hold_vld, cnt=0. Next state: DATA. Lasts one cycle; no strobe is consumed.
- DATA, on each clk_trans cycle:
  - tx_bit <= shift[0]; tx_bit_valid=1; shift >>= 1; cnt++.
  - fb = crc[15] ^ shift[0]; crc <= {crc[14:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - On the strobe where cnt==7 (8th bit), the first matching rule applies:
    - hold_vld: reload shift from hold in the same cycle, cnt=0, stay in DATA. No gap between bytes.
    - the current byte was last: go to CRC if the latched crc_en is 1, else DONE.
    - otherwise (underrun): pulse tx_err and go to IDLE. No CRC is sent.
- CRC: on each clk_trans, tx_bit <= ~crc[15]; tx_bit_valid=1; crc <= {crc[14:0],1'b0}; 4-bit counter. The 16th strobe goes to DONE.
- DONE: tx_done=1 for one cycle, then IDLE.
- Latency: the first payload bit appears on the first clk_trans strobe at least 2 cycles after acceptance (IDLE→LOAD→DATA).
- Packet length in strobes = 8*N + (crc_en ? 16 : 0); a ZLP takes exactly 16.
- clk_trans in IDLE, LOAD or DONE is ignored.
- abort has priority over everything:
  - Next state IDLE; hold_vld, last_seen and cnt cleared.
  - No tx_done or tx_err; tx_bit_valid=0 that cycle. tx_bit keeps its value.
- rst_n asserted mid-packet restores reset values immediately (asynchronous). There is no partial flush.
- tx_valid is sampled only when tx_ready=1. tx_data and tx_last must be stable while tx_valid is high.

Decomposition:
- Package usb_pkg: state enum (IDLE, LOAD, DATA, CRC, DONE), CRC16_INIT, CRC16_POLY, CRC16_RESIDUAL (16'h800D, for the receive checker).
- One sub-module, usb_crc16_gen. It holds the 16-bit LFSR with synchronous init, shift_en and data_in/dump controls, and exposes crc_msb. The sequencer owns all counters and the state.

Test Plan:
- ZLP: tx_zlp pulse with clk_trans every 4 cycles → exactly 16 tx_bit_valid pulses, all tx_bit=0 (CRC of nothing = 16'h0000), then tx_done one cycle after the 16th strobe, tx_busy low after.
- Single byte 0x01, crc_en=1, tx_last=1 → data bits 1,0,0,0,0,0,0,0, then 16 CRC bits matching the golden-model CRC16 (init FFFF, poly 8005, inverted, MSB first); 24 strobes total.
- Four back-to-back bytes 00 01 02 03 with tx_valid held high → tx_ready drops after each acceptance and reasserts on reload; 32 contiguous data strobes with no gap and no extra strobe, then CRC; tx_bit stream matches the model.
- Underrun: byte 0xA5 with tx_last=0 and no further tx_valid → 8 bits 1,0,1,0,0,1,0,1, tx_err pulse on the 8th strobe edge, state IDLE, no CRC bits.
- crc_en=0, bytes 0xFF,0x00 with last → 16 strobes (eight 1s then eight 0s), tx_done, no CRC bits.
- abort on the 5th data strobe of a 2-byte packet → tx_bit_valid not pulsed that cycle; IDLE next cycle, tx_ready=1; a subsequent ZLP produces 16 zeros, proving crc re-init. Also apply rst_n low mid-CRC → all outputs at reset values within the same cycle.
